// File: rtl/id_pipe_pkg.sv
// Shared decode-stage definitions: instruction field codes, ALU encodings and
// the hazard-controller state encoding.
package id_pipe_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_PREF    = 6'b110011;

   localparam logic [5:0] FN_SLL     = 6'b000000;
   localparam logic [5:0] FN_SRL     = 6'b000010;
   localparam logic [5:0] FN_SRA     = 6'b000011;
   localparam logic [5:0] FN_SLLV    = 6'b000100;
   localparam logic [5:0] FN_SRLV    = 6'b000110;
   localparam logic [5:0] FN_SRAV    = 6'b000111;
   localparam logic [5:0] FN_SYNC    = 6'b001111;
   localparam logic [5:0] FN_AND     = 6'b100100;
   localparam logic [5:0] FN_OR      = 6'b100101;
   localparam logic [5:0] FN_XOR     = 6'b100110;
   localparam logic [5:0] FN_NOR     = 6'b100111;

   localparam logic [7:0] ALUOP_NOP  = 8'b00000000;
   localparam logic [7:0] ALUOP_AND  = 8'b00100100;
   localparam logic [7:0] ALUOP_OR   = 8'b00100101;
   localparam logic [7:0] ALUOP_XOR  = 8'b00100110;
   localparam logic [7:0] ALUOP_NOR  = 8'b00100111;
   localparam logic [7:0] ALUOP_SLL  = 8'b01111100;
   localparam logic [7:0] ALUOP_SRL  = 8'b00000010;
   localparam logic [7:0] ALUOP_SRA  = 8'b00000011;

   localparam logic [2:0] ALUSEL_NOP   = 3'b000;
   localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
   localparam logic [2:0] ALUSEL_SHIFT = 3'b010;

   localparam logic [4:0] NOP_REG_ADDR = 5'd0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic logic [31:0] zext16(input logic [15:0] v);
      return {16'h0000, v};
   endfunction

endpackage

// File: rtl/id_pipe_decoder.sv
// Combinational instruction decoder for the logic/shift/immediate subset.
// Unrecognised words come out with decoded=0, no register reads and no write-back.
module id_decoder
   import id_pipe_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
) (
   input  logic [31:0]         inst,
   output logic [ALUOP_W-1:0]  aluop,
   output logic [ALUSEL_W-1:0] alusel,
   output logic                reg1_read,
   output logic                reg2_read,
   output logic [DATA_W-1:0]   imm,
   output logic [RADDR_W-1:0]  wd,
   output logic                wreg,
   output logic                decoded
);

   logic [5:0]  op;
   logic [5:0]  fn;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sa;
   logic [15:0] imm16;

   assign op    = inst[31:26];
   assign rs    = inst[25:21];
   assign rt    = inst[20:16];
   assign rd    = inst[15:11];
   assign sa    = inst[10:6];
   assign fn    = inst[5:0];
   assign imm16 = inst[15:0];

   always_comb begin
      aluop     = ALUOP_W'(ALUOP_NOP);
      alusel    = ALUSEL_W'(ALUSEL_NOP);
      reg1_read = 1'b0;
      reg2_read = 1'b0;
      imm       = '0;
      wd        = RADDR_W'(NOP_REG_ADDR);
      wreg      = 1'b0;
      decoded   = 1'b0;

      // Immediate shifts take priority: SLL $0,$0,0 is the canonical NOP word.
      if ({op, rs} == 11'd0 && (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA)) begin
         wreg      = 1'b1;
         wd        = RADDR_W'(rd);
         reg2_read = 1'b1;
         imm       = DATA_W'(sa);
         alusel    = ALUSEL_W'(ALUSEL_SHIFT);
         decoded   = 1'b1;
         case (fn)
            FN_SLL:  aluop = ALUOP_W'(ALUOP_SLL);
            FN_SRL:  aluop = ALUOP_W'(ALUOP_SRL);
            default: aluop = ALUOP_W'(ALUOP_SRA);
         endcase
      end else if (op == OP_SPECIAL && sa == 5'd0) begin
         case (fn)
            FN_OR, FN_AND, FN_XOR, FN_NOR: begin
               wreg      = 1'b1;
               wd        = RADDR_W'(rd);
               reg1_read = 1'b1;
               reg2_read = 1'b1;
               alusel    = ALUSEL_W'(ALUSEL_LOGIC);
               decoded   = 1'b1;
               case (fn)
                  FN_OR:   aluop = ALUOP_W'(ALUOP_OR);
                  FN_AND:  aluop = ALUOP_W'(ALUOP_AND);
                  FN_XOR:  aluop = ALUOP_W'(ALUOP_XOR);
                  default: aluop = ALUOP_W'(ALUOP_NOR);
               endcase
            end
            FN_SLLV, FN_SRLV, FN_SRAV: begin
               wreg      = 1'b1;
               wd        = RADDR_W'(rd);
               reg1_read = 1'b1;
               reg2_read = 1'b1;
               alusel    = ALUSEL_W'(ALUSEL_SHIFT);
               decoded   = 1'b1;
               case (fn)
                  FN_SLLV: aluop = ALUOP_W'(ALUOP_SLL);
                  FN_SRLV: aluop = ALUOP_W'(ALUOP_SRL);
                  default: aluop = ALUOP_W'(ALUOP_SRA);
               endcase
            end
            FN_SYNC: begin
               reg2_read = 1'b1;
               decoded   = 1'b1;
            end
            default: ;
         endcase
      end else begin
         case (op)
            OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
               wreg      = 1'b1;
               wd        = RADDR_W'(rt);
               reg1_read = 1'b1;
               alusel    = ALUSEL_W'(ALUSEL_LOGIC);
               decoded   = 1'b1;
               imm       = DATA_W'(zext16(imm16));
               case (op)
                  OP_ANDI: aluop = ALUOP_W'(ALUOP_AND);
                  OP_XORI: aluop = ALUOP_W'(ALUOP_XOR);
                  OP_LUI: begin
                     aluop = ALUOP_W'(ALUOP_OR);
                     imm   = DATA_W'({imm16, 16'h0000});
                  end
                  default: aluop = ALUOP_W'(ALUOP_OR);
               endcase
            end
            OP_PREF: decoded = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/id_pipe.sv
// Decode stage with built-in ID/EX register: operand forwarding from prioritised
// write-back sources, load-use hazard hold, and stall/flush handling.
module id_pipe
   import id_pipe_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5,
   parameter int NUM_FWD  = 2,
   parameter int LOAD_LAT = 1,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        inst_valid_i,
   input  logic [31:0]                 pc_i,
   input  logic [31:0]                 inst_i,
   input  logic [DATA_W-1:0]           reg1_data_i,
   input  logic [DATA_W-1:0]           reg2_data_i,
   input  logic [NUM_FWD-1:0]          fwd_wreg_i,
   input  logic [NUM_FWD*RADDR_W-1:0]  fwd_wd_i,
   input  logic [NUM_FWD*DATA_W-1:0]   fwd_wdata_i,
   input  logic                        ex_is_load_i,
   input  logic                        stall_i,
   input  logic                        flush_i,
   output logic                        reg1_read_o,
   output logic                        reg2_read_o,
   output logic [RADDR_W-1:0]          reg1_addr_o,
   output logic [RADDR_W-1:0]          reg2_addr_o,
   output logic                        inst_ready_o,
   output logic                        ex_valid_o,
   output logic [ALUOP_W-1:0]          ex_aluop_o,
   output logic [ALUSEL_W-1:0]         ex_alusel_o,
   output logic [DATA_W-1:0]           ex_reg1_o,
   output logic [DATA_W-1:0]           ex_reg2_o,
   output logic [RADDR_W-1:0]          ex_wd_o,
   output logic                        ex_wreg_o,
   output logic                        ex_invalid_o
);

   // state   | meaning
   // ST_RUN  | normal issue; a load-use hazard inserts the first bubble here
   // ST_HOLD | instruction held in ID, bubbles issued until cnt reaches 1

   localparam int CNT_W = $clog2(LOAD_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

   typedef struct packed {
      logic                valid;
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [DATA_W-1:0]   reg1;
      logic [DATA_W-1:0]   reg2;
      logic [RADDR_W-1:0]  wd;
      logic                wreg;
      logic                invalid;
   } ex_t;

   logic [ALUOP_W-1:0]  dec_aluop;
   logic [ALUSEL_W-1:0] dec_alusel;
   logic [DATA_W-1:0]   dec_imm;
   logic [RADDR_W-1:0]  dec_wd;
   logic                dec_wreg;
   logic                dec_ok;

   logic [NUM_FWD-1:0]  hit1_vec;
   logic [NUM_FWD-1:0]  hit2_vec;
   logic [DATA_W-1:0]   src_data [NUM_FWD];
   logic [DATA_W-1:0]   op1;
   logic [DATA_W-1:0]   op2;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                hazard;
   logic                bubble;
   ex_t                 ex_q;
   logic                unused_pc;

   assign unused_pc = ^pc_i;

   id_decoder #(
      .DATA_W   (DATA_W),
      .RADDR_W  (RADDR_W),
      .ALUOP_W  (ALUOP_W),
      .ALUSEL_W (ALUSEL_W)
   ) u_decoder (
      .inst      (inst_i),
      .aluop     (dec_aluop),
      .alusel    (dec_alusel),
      .reg1_read (reg1_read_o),
      .reg2_read (reg2_read_o),
      .imm       (dec_imm),
      .wd        (dec_wd),
      .wreg      (dec_wreg),
      .decoded   (dec_ok)
   );

   assign reg1_addr_o = RADDR_W'(inst_i[25:21]);
   assign reg2_addr_o = RADDR_W'(inst_i[20:16]);

   for (genvar g = 0; g < NUM_FWD; g++) begin : g_fwd
      logic [RADDR_W-1:0] src_wd;
      assign src_wd      = fwd_wd_i[g*RADDR_W +: RADDR_W];
      assign src_data[g] = fwd_wdata_i[g*DATA_W +: DATA_W];
      assign hit1_vec[g] = fwd_wreg_i[g] && (src_wd == reg1_addr_o) && (reg1_addr_o != '0);
      assign hit2_vec[g] = fwd_wreg_i[g] && (src_wd == reg2_addr_o) && (reg2_addr_o != '0);
   end

   // Scan from the oldest source down so the youngest match is the last write.
   always_comb begin
      op1 = reg1_data_i;
      op2 = reg2_data_i;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (hit1_vec[i]) op1 = src_data[i];
         if (hit2_vec[i]) op2 = src_data[i];
      end
      if (!reg1_read_o)            op1 = dec_imm;
      else if (reg1_addr_o == '0)  op1 = '0;
      if (!reg2_read_o)            op2 = dec_imm;
      else if (reg2_addr_o == '0)  op2 = '0;
   end

   assign hazard = inst_valid_i && (state == ST_RUN) && ex_is_load_i &&
                   ((reg1_read_o && hit1_vec[0]) || (reg2_read_o && hit2_vec[0]));

   assign inst_ready_o = !rst && !stall_i && !flush_i && (state == ST_RUN) && !hazard;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bubble    = 1'b0;
      if (flush_i) begin
         state_nxt = ST_RUN;
         cnt_nxt   = '0;
      end else if (!stall_i) begin
         case (state)
            ST_RUN: begin
               if (hazard) begin
                  bubble = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_nxt = ST_HOLD;
                     cnt_nxt   = CNT_RELOAD;
                  end
               end
            end
            ST_HOLD: begin
               bubble  = 1'b1;
               cnt_nxt = cnt - 1'b1;
               if (cnt == CNT_LAST) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         ex_q <= '0;
      end else if (!stall_i) begin
         if (bubble || !inst_valid_i) begin
            ex_q <= '0;
         end else begin
            ex_q.valid   <= 1'b1;
            ex_q.aluop   <= dec_aluop;
            ex_q.alusel  <= dec_alusel;
            ex_q.reg1    <= op1;
            ex_q.reg2    <= op2;
            ex_q.wd      <= dec_wd;
            ex_q.wreg    <= dec_wreg;
            ex_q.invalid <= !dec_ok;
         end
      end
   end

   assign ex_valid_o   = ex_q.valid;
   assign ex_aluop_o   = ex_q.aluop;
   assign ex_alusel_o  = ex_q.alusel;
   assign ex_reg1_o    = ex_q.reg1;
   assign ex_reg2_o    = ex_q.reg2;
   assign ex_wd_o      = ex_q.wd;
   assign ex_wreg_o    = ex_q.wreg;
   assign ex_invalid_o = ex_q.invalid;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe (LOAD_LAT=2): behavioural pipeline model compared
// every cycle, plus hand-computed expectations at key points.
module tb_id_pipe;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] inst;
   logic [31:0] reg1_data;
   logic [31:0] reg2_data;
   logic [1:0]  fwd_wreg;
   logic [9:0]  fwd_wd;
   logic [63:0] fwd_wdata;
   logic        ex_is_load;
   logic        stall;
   logic        flush;
   logic        reg1_read, reg2_read;
   logic [4:0]  reg1_addr, reg2_addr;
   logic        inst_ready;
   logic        ex_valid;
   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [31:0] ex_reg1, ex_reg2;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic        ex_invalid;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   id_pipe #(.LOAD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .inst_valid_i(inst_valid), .pc_i(pc), .inst_i(inst),
      .reg1_data_i(reg1_data), .reg2_data_i(reg2_data),
      .fwd_wreg_i(fwd_wreg), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
      .ex_is_load_i(ex_is_load), .stall_i(stall), .flush_i(flush),
      .reg1_read_o(reg1_read), .reg2_read_o(reg2_read),
      .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
      .inst_ready_o(inst_ready), .ex_valid_o(ex_valid), .ex_aluop_o(ex_aluop),
      .ex_alusel_o(ex_alusel), .ex_reg1_o(ex_reg1), .ex_reg2_o(ex_reg2),
      .ex_wd_o(ex_wd), .ex_wreg_o(ex_wreg), .ex_invalid_o(ex_invalid)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        ok;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic        r1;
      logic        r2;
      logic [31:0] imm;
      logic [4:0]  wd;
      logic        wreg;
   } dec_t;

   typedef struct packed {
      logic        valid;
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic        invalid;
   } mex_t;

   function automatic dec_t mdec(input logic [31:0] w);
      dec_t d;
      logic [5:0] op, fn;
      logic [4:0] rt, rd, sa;
      d  = '0;
      op = w[31:26]; fn = w[5:0]; rt = w[20:16]; rd = w[15:11]; sa = w[10:6];
      if (w[31:21] == 11'd0 && fn inside {6'h00, 6'h02, 6'h03}) begin
         d.ok = 1; d.wreg = 1; d.wd = rd; d.r2 = 1; d.imm = {27'd0, sa}; d.alusel = 3'd2;
         d.aluop = (fn == 6'h00) ? 8'h7C : (fn == 6'h02) ? 8'h02 : 8'h03;
      end else if (op == 0 && sa == 0 && fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
         d.ok = 1; d.wreg = 1; d.wd = rd; d.r1 = 1; d.r2 = 1; d.alusel = 3'd1;
         d.aluop = {2'b00, fn};
      end else if (op == 0 && sa == 0 && fn inside {6'h04, 6'h06, 6'h07}) begin
         d.ok = 1; d.wreg = 1; d.wd = rd; d.r1 = 1; d.r2 = 1; d.alusel = 3'd2;
         d.aluop = (fn == 6'h04) ? 8'h7C : (fn == 6'h06) ? 8'h02 : 8'h03;
      end else if (op == 0 && sa == 0 && fn == 6'h0F) begin
         d.ok = 1; d.r2 = 1;
      end else if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
         d.ok = 1; d.wreg = 1; d.wd = rt; d.r1 = 1; d.alusel = 3'd1;
         d.imm = {16'h0, w[15:0]};
         case (op)
            6'h0C:   d.aluop = 8'h24;
            6'h0E:   d.aluop = 8'h26;
            6'h0F: begin d.aluop = 8'h25; d.imm = {w[15:0], 16'h0}; end
            default: d.aluop = 8'h25;
         endcase
      end else if (op == 6'h33) begin
         d.ok = 1;
      end
      return d;
   endfunction

   function automatic logic [31:0] mop(input logic rd, input logic [4:0] a,
                                       input logic [31:0] imm, input logic [31:0] rf);
      if (!rd) return imm;
      if (a == 0) return 32'd0;
      for (int i = 0; i < 2; i++)
         if (fwd_wreg[i] && fwd_wd[i*5 +: 5] == a) return fwd_wdata[i*32 +: 32];
      return rf;
   endfunction

   int   m_left = 0;  // bubbles still owed for the held instruction
   bit   m_started = 0;
   mex_t m_ex = '0;

   function automatic bit m_haz();
      dec_t d;
      logic [4:0] w0;
      d  = mdec(inst);
      w0 = fwd_wd[4:0];
      return inst_valid && m_left == 0 && ex_is_load && fwd_wreg[0] &&
             ((d.r1 && inst[25:21] == w0 && w0 != 0) || (d.r2 && inst[20:16] == w0 && w0 != 0));
   endfunction

   always @(posedge clk) begin : model
      dec_t d;
      d = mdec(inst);
      if (rst) begin
         m_ex = '0; m_left = 0; m_started = 1;
      end else if (flush) begin
         m_ex = '0; m_left = 0;
      end else if (stall) begin
         m_ex = m_ex;
      end else if (m_left > 0) begin
         m_ex = '0; m_left = m_left - 1;
      end else if (m_haz()) begin
         m_ex = '0; m_left = LAT - 1;
      end else if (!inst_valid) begin
         m_ex = '0;
      end else begin
         m_ex.valid   = 1'b1;
         m_ex.aluop   = d.aluop;
         m_ex.alusel  = d.alusel;
         m_ex.reg1    = mop(d.r1, inst[25:21], d.imm, reg1_data);
         m_ex.reg2    = mop(d.r2, inst[20:16], d.imm, reg2_data);
         m_ex.wd      = d.wd;
         m_ex.wreg    = d.wreg;
         m_ex.invalid = !d.ok;
      end
   end

   always @(negedge clk) begin : compare
      dec_t d;
      if (m_started) begin
         d = mdec(inst);
         chk("ex_valid",   ex_valid,   m_ex.valid);
         chk("ex_aluop",   ex_aluop,   m_ex.aluop);
         chk("ex_alusel",  ex_alusel,  m_ex.alusel);
         chk("ex_reg1",    ex_reg1,    m_ex.reg1);
         chk("ex_reg2",    ex_reg2,    m_ex.reg2);
         chk("ex_wd",      ex_wd,      m_ex.wd);
         chk("ex_wreg",    ex_wreg,    m_ex.wreg);
         chk("ex_invalid", ex_invalid, m_ex.invalid);
         chk("reg1_addr",  reg1_addr,  inst[25:21]);
         chk("reg2_addr",  reg2_addr,  inst[20:16]);
         chk("reg1_read",  reg1_read,  d.r1);
         chk("reg2_read",  reg2_read,  d.r2);
         chk("inst_ready", inst_ready,
             !rst && !stall && !flush && m_left == 0 && !m_haz());
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic fwd(input int s, input logic we, input logic [4:0] a, input logic [31:0] dat);
      fwd_wreg[s]          = we;
      fwd_wd[s*5 +: 5]     = a;
      fwd_wdata[s*32 +: 32] = dat;
   endtask

   task automatic issue(input logic [31:0] w);
      inst = w; inst_valid = 1'b1; pc = pc + 32'd4;
   endtask

   localparam logic [31:0] I_AND = 32'h00862824;  // AND $5,$4,$6

   task automatic load_hazard();
      issue(I_AND);
      fwd(1, 0, 0, 0);
      fwd(0, 1, 4, 32'h0);
      ex_is_load = 1'b1;
   endtask

   task automatic clear_fwd();
      fwd(0, 0, 0, 0); fwd(1, 0, 0, 0); ex_is_load = 1'b0;
   endtask

   initial begin
      rst = 1; inst_valid = 0; pc = 0; inst = 0; reg1_data = 0; reg2_data = 0;
      fwd_wreg = 0; fwd_wd = 0; fwd_wdata = 0; ex_is_load = 0; stall = 0; flush = 0;
      cyc(2);
      chk("lit reset ex_valid", ex_valid, 0);
      chk("lit reset ex_wreg", ex_wreg, 0);
      chk("lit reset ready", inst_ready, 0);
      rst = 0;

      issue(32'h34011234); reg1_data = 32'hDEAD;  // ORI $1,$0,0x1234
      #1 chk("lit ori ready", inst_ready, 1);
      cyc();
      chk("lit ori reg1", ex_reg1, 0);
      chk("lit ori reg2", ex_reg2, 32'h1234);
      chk("lit ori wd", ex_wd, 1);
      chk("lit ori wreg", ex_wreg, 1);

      issue(32'h00221825); reg2_data = 32'h22;    // OR $3,$1,$2
      fwd(0, 1, 1, 32'hA); fwd(1, 1, 1, 32'hB);
      cyc();
      chk("lit or fwd prio", ex_reg1, 32'hA);
      chk("lit or reg2", ex_reg2, 32'h22);
      chk("lit or aluop", ex_aluop, 8'h25);

      fwd(0, 1, 0, 32'hFF); fwd(1, 0, 0, 0);
      issue(32'h00021825);                         // OR $3,$0,$2
      cyc();
      chk("lit no $0 fwd", ex_reg1, 0);

      clear_fwd();
      issue(32'h3C07BEEF); cyc();                  // LUI $7,0xBEEF
      chk("lit lui reg2", ex_reg2, 32'hBEEF0000);
      issue(32'h000240C0); cyc();                  // SLL $8,$2,3
      chk("lit sll reg1", ex_reg1, 3);
      chk("lit sll alusel", ex_alusel, 3'd2);
      chk("lit sll wd", ex_wd, 8);

      // load-use, 2 bubbles
      load_hazard(); reg1_data = 32'h999; reg2_data = 32'h66;
      #1 chk("lit lu ready0", inst_ready, 0);
      cyc();
      chk("lit lu bubble0", ex_valid, 0);
      clear_fwd(); fwd(1, 1, 4, 32'h44);
      #1 chk("lit lu ready1", inst_ready, 0);
      cyc();
      chk("lit lu bubble1", ex_valid, 0);
      chk("lit lu ready2", inst_ready, 1);
      cyc();
      chk("lit lu issue", ex_valid, 1);
      chk("lit lu reg1", ex_reg1, 32'h44);
      chk("lit lu aluop", ex_aluop, 8'h24);

      // stall during HOLD freezes the countdown
      load_hazard(); cyc();
      clear_fwd(); reg1_data = 32'h4444; stall = 1;
      cyc(2);
      chk("lit stall ready", inst_ready, 0);
      stall = 0;
      #1 chk("lit post stall hold", inst_ready, 0);
      cyc();
      chk("lit post stall bubble", ex_valid, 0);
      cyc();
      chk("lit post stall issue", ex_reg1, 32'h4444);
      issue(32'h34011234); stall = 1; cyc();
      chk("lit stall holds ex", ex_aluop, 8'h24);
      stall = 0;

      // flush mid-HOLD
      load_hazard(); cyc();
      flush = 1; cyc();
      chk("lit flush hold", ex_valid, 0);
      flush = 0; clear_fwd();
      #1 chk("lit flush run", inst_ready, 1);
      issue(32'h34011234); cyc();
      chk("lit pre flush valid", ex_valid, 1);
      flush = 1; stall = 1; cyc();
      chk("lit flush beats stall", ex_valid, 0);
      flush = 0; stall = 0;

      // reset mid-hazard
      load_hazard(); cyc();
      rst = 1; cyc();
      chk("lit rst ex_valid", ex_valid, 0);
      chk("lit rst ex_aluop", ex_aluop, 0);
      rst = 0; clear_fwd();
      #1 chk("lit rst run", inst_ready, 1);

      issue(32'hFC000000); cyc();
      chk("lit invalid flag", ex_invalid, 1);
      chk("lit invalid wreg", ex_wreg, 0);
      chk("lit invalid valid", ex_valid, 1);

      inst_valid = 0; cyc();
      chk("lit idle bubble", ex_valid, 0);
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
